moxie_wb_ram16: RTL and testbench

- Wishbone classic slave (responder): 16-bit on-chip RAM serving the 16-bit MoxieLite Wishbone master bus (32-bit byte address, 2-bit byte select).
- Inserts a programmable number of wait states, issues a single-cycle registered ack, and forces a one-cycle turnaround so a strobe the master still holds is never double-counted.
- Sits on the CPU bus beside other slaves. An address decode gate keeps it silent outside its window.

---
 rtl/moxie_wb_pkg.sv | 19 +
 rtl/moxie_ram16_be.sv | 48 ++++
 rtl/moxie_wb_ram16.sv | 183 ++++++++++++++++++
 tb/tb_moxie_wb_ram16.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/moxie_wb_pkg.sv
// moxie_wb_pkg
// Shared definitions for the MoxieLite 16-bit Wishbone RAM slave:
//   - bus widths of the MoxieLite Wishbone master (data, address, byte select)
//   - controller state encoding (IDLE -> WAIT -> ACK -> TURN -> IDLE)
package moxie_wb_pkg;

  localparam int WB_DW   = 16;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 2;

  // Gray-style encoding so each legal transition flips a single bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b11,
    TURN = 2'b10
  } wbState_e;

endpackage

// File: rtl/moxie_ram16_be.sv
// moxie_ram16_be
// Synchronous single-port 2**ADDR_WIDTH x 16 RAM with per-byte write enables
// and a registered read port (one cycle read latency).
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (clears only the read register)
//   addr_i    word address
//   wbe_i     byte write enables, [1] = bits 15:8, [0] = bits 7:0
//   re_i      read enable; rdata_o updates after the edge where it is high
//   wdata_i   write data
//   rdata_o   registered read data, holds until the next read
module moxie_ram16_be
  import moxie_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [WB_SELW-1:0]        wbe_i,
  input  logic                      re_i,
  input  logic [WB_DW-1:0]          wdata_i,
  output logic [WB_DW-1:0]          rdata_o
);

  localparam int Depth = 2 ** ADDR_WIDTH;

  logic [WB_DW-1:0] mem [Depth];
  logic [WB_DW-1:0] rdata_q;

  // Array writes, one enable per byte lane. The array is never reset.
  always_ff @(posedge clk_i) begin
    if (wbe_i[1]) mem[addr_i][15:8] <= wdata_i[15:8];
    if (wbe_i[0]) mem[addr_i][7:0]  <= wdata_i[7:0];
  end

  // Read register: loaded only on a read so the last read word is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/moxie_wb_ram16.sv
// moxie_wb_ram16
// Wishbone classic slave: 16-bit on-chip RAM for the MoxieLite CPU bus.
// A request is captured in IDLE, waits WAIT_STATES cycles, is performed at
// the ack edge, and is followed by one ACK cycle and one TURN cycle so a
// strobe the master still holds is not counted twice.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   wb_adr_i       byte address (bit 0 ignored), decoded against BASE_ADDR
//   wb_dat_i       write data
//   wb_dat_o       read data, valid with ack, held until the next read
//   wb_sel_i       byte lanes, [1] = bits 15:8, [0] = bits 7:0
//   wb_we_i        1 = write
//   wb_cyc_i       bus cycle
//   wb_stb_i       strobe
//   wb_ack_o       single-cycle registered ack
// Build option:
//   MOXIE_WB_RAM16_RDBYPASS_EN  serve a read of the word just written from a
//                               bypass register instead of the array.
module moxie_wb_ram16
  import moxie_wb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_AW-1:0]    wb_adr_i,
  input  logic [WB_DW-1:0]    wb_dat_i,
  output logic [WB_DW-1:0]    wb_dat_o,
  input  logic [WB_SELW-1:0]  wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  wbState_e                state_q, state_d;
  logic [3:0]              waitCnt_q, waitCnt_d;
  logic                    ack_q, ack_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [WB_SELW-1:0]      sel_q, sel_d;
  logic [WB_DW-1:0]        wdat_q, wdat_d;

  logic                    busReq;
  logic                    hit;
  logic                    access;
  logic                    bypassHit;
  logic                    ramRe;
  logic [WB_SELW-1:0]      ramWbe;
  logic [WB_DW-1:0]        ramRdata;
  logic                    unusedAdr;

  assign unusedAdr = wb_adr_i[0];

  assign busReq = wb_cyc_i & wb_stb_i;
  assign hit    = busReq &
                  (wb_adr_i[WB_AW-1:ADDR_WIDTH+1] == BASE_ADDR[WB_AW-1:ADDR_WIDTH+1]);

  // Next-state logic. The access itself (array read or write) happens on the
  // edge that leaves WAIT with a zero counter, which is also the ack edge.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    ack_d     = 1'b0;
    idx_d     = idx_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    access    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          idx_d     = wb_adr_i[ADDR_WIDTH:1];
          we_d      = wb_we_i;
          sel_d     = wb_sel_i;
          wdat_d    = wb_dat_i;
          waitCnt_d = WaitLoad;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!busReq) begin
          state_d = IDLE;
        end else if (waitCnt_q == 4'd0) begin
          access  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      ACK:  state_d = TURN;
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers. Reset drops any pending request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      ack_q     <= ack_d;
    end
  end

  // Latched request fields; only meaningful after a capture, so no reset.
  always_ff @(posedge clk_i) begin
    idx_q  <= idx_d;
    we_q   <= we_d;
    sel_q  <= sel_d;
    wdat_q <= wdat_d;
  end

  // Array strobes are gated by reset so a write pending at reset is dropped.
  assign ramRe  = access & ~we_q & ~rst_i & ~bypassHit;
  assign ramWbe = (access & we_q & ~rst_i) ? sel_q : '0;

  moxie_ram16_be #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (idx_q),
    .wbe_i   (ramWbe),
    .re_i    (ramRe),
    .wdata_i (wdat_q),
    .rdata_o (ramRdata)
  );

`ifdef MOXIE_WB_RAM16_RDBYPASS_EN
  logic                  bypassValid_q;
  logic [ADDR_WIDTH-1:0] bypassIdx_q;
  logic [WB_DW-1:0]      bypassData_q;
  logic [WB_DW-1:0]      bypassOut_q;
  logic                  useBypass_q;

  // Only a full-word write leaves a complete word in the bypass register;
  // partial writes and any read invalidate it.
  assign bypassHit = access & ~we_q & bypassValid_q & (bypassIdx_q == idx_q);

  // Bypass capture and the separate output hold register, which keeps the
  // bypassed word stable across later writes until the next read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bypassValid_q <= 1'b0;
      useBypass_q   <= 1'b0;
      bypassOut_q   <= '0;
    end else if (access) begin
      if (we_q) begin
        bypassValid_q <= (sel_q == 2'b11);
      end else begin
        bypassValid_q <= 1'b0;
        useBypass_q   <= bypassHit;
        if (bypassHit) bypassOut_q <= bypassData_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (access && we_q) begin
      bypassIdx_q  <= idx_q;
      bypassData_q <= wdat_q;
    end
  end

  assign wb_dat_o = useBypass_q ? bypassOut_q : ramRdata;
`else
  assign bypassHit = 1'b0;
  assign wb_dat_o  = ramRdata;
`endif

  assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_moxie_wb_ram16.sv
// tb_moxie_wb_ram16
// Directed bench for moxie_wb_ram16. Two instances share the bus: dut1 at
// BASE_ADDR 0 and dut2 at BASE_ADDR 32'h0001_0000, both WAIT_STATES = 1.
module tb_moxie_wb_ram16;

  localparam int WS      = 1;
  localparam int EXP_LAT = WS + 2;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [15:0] datW;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        useDut2;

  logic [15:0] dat1, dat2, rdat;
  logic        ack1, ack2, ack;

  int checks   = 0;
  int failures = 0;

  moxie_wb_ram16 #(.ADDR_WIDTH(12), .WAIT_STATES(WS), .BASE_ADDR(32'h0000_0000)) dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_adr_i (adr),
    .wb_dat_i (datW),
    .wb_dat_o (dat1),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc & ~useDut2),
    .wb_stb_i (stb & ~useDut2),
    .wb_ack_o (ack1)
  );

  moxie_wb_ram16 #(.ADDR_WIDTH(12), .WAIT_STATES(WS), .BASE_ADDR(32'h0001_0000)) dut2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_adr_i (adr),
    .wb_dat_i (datW),
    .wb_dat_o (dat2),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc & useDut2),
    .wb_stb_i (stb & useDut2),
    .wb_ack_o (ack2)
  );

  assign ack  = useDut2 ? ack2 : ack1;
  assign rdat = useDut2 ? dat2 : dat1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete handshake: raise cyc/stb, count edges until ack (bounded),
  // check the ack is a single-cycle pulse, then idle until the slave is back
  // in IDLE so the next call's first edge is a capture edge.
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [1:0] s,
                               input logic [15:0] d, output int lat, output logic [15:0] rd);
    adr  = a;
    we   = w;
    sel  = s;
    datW = d;
    cyc  = 1'b1;
    stb  = 1'b1;
    lat  = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 20);
    rd  = rdat;
    cyc = 1'b0;
    stb = 1'b0;
    @(posedge clk); #1;
    checkOutput("ackPulse", ack, 1'b0);
    @(posedge clk); #1;
  endtask

  // Count ack-high samples over n cycles with the bus left as it is.
  task automatic watchAcks(input int n, inout int cnt);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ack) cnt++;
    end
  endtask

  initial begin
    int          lat;
    int          acks;
    int          c1, c2;
    logic [15:0] rd, d1, d2;

    rst = 1'b1; adr = '0; datW = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; useDut2 = 1'b0;
    c1 = 0; c2 = 0; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAck", ack1, 1'b0);
    checkOutput("rstDat", dat1, 16'h0000);
    checkOutput("rstDat2", dat2, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] full write and read back");
    applyStimulus(32'h10, 1'b1, 2'b11, 16'hBEEF, lat, rd);
    checkOutput("wrLat", lat, EXP_LAT);
    applyStimulus(32'h10, 1'b0, 2'b11, 16'h0000, lat, rd);
    checkOutput("rdLat", lat, EXP_LAT);
    checkOutput("rdBeef", rd, 16'hBEEF);

    $display("[TB] byte lanes");
    applyStimulus(32'h10, 1'b1, 2'b01, 16'h1234, lat, rd);
    checkOutput("wrLoLat", lat, EXP_LAT);
    applyStimulus(32'h10, 1'b0, 2'b00, 16'h0000, lat, rd);
    checkOutput("rdLo", rd, 16'hBE34);
    applyStimulus(32'h10, 1'b1, 2'b00, 16'hFFFF, lat, rd);
    checkOutput("wrNoneLat", lat, EXP_LAT);
    applyStimulus(32'h10, 1'b0, 2'b11, 16'h0000, lat, rd);
    checkOutput("rdNone", rd, 16'hBE34);

    $display("[TB] abort during WAIT");
    applyStimulus(32'h20, 1'b1, 2'b11, 16'h7777, lat, rd);
    checkOutput("wrPriorLat", lat, EXP_LAT);
    checkOutput("datHeldOnWr", dat1, 16'hBE34);
    adr = 32'h20; we = 1'b1; sel = 2'b11; datW = 16'h5555; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    watchAcks(2, acks);
    cyc = 1'b0; stb = 1'b0;
    watchAcks(20, acks);
    checkOutput("abortNoAck", acks, 0);
    applyStimulus(32'h20, 1'b0, 2'b11, 16'h0000, lat, rd);
    checkOutput("abortKeep", rd, 16'h7777);

    $display("[TB] read right after write of same word");
    applyStimulus(32'h30, 1'b1, 2'b11, 16'hC3C3, lat, rd);
    applyStimulus(32'h30, 1'b0, 2'b11, 16'h0000, lat, rd);
    checkOutput("rawLat", lat, EXP_LAT);
    checkOutput("rawData", rd, 16'hC3C3);

    $display("[TB] continuous strobe");
    applyStimulus(32'h0, 1'b1, 2'b11, 16'hAAAA, lat, rd);
    applyStimulus(32'h2, 1'b1, 2'b11, 16'h5B5B, lat, rd);
    adr = 32'h0; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        if (acks == 1) begin
          c1  = i;
          d1  = rdat;
          adr = 32'h2;
        end else begin
          c2  = i;
          d2  = rdat;
          cyc = 1'b0;
          stb = 1'b0;
        end
      end
    end
    checkOutput("contAcks", acks, 2);
    checkOutput("contFirst", c1, EXP_LAT);
    checkOutput("contSpacing", c2 - c1, WS + 4);
    checkOutput("contD1", d1, 16'hAAAA);
    checkOutput("contD2", d2, 16'h5B5B);

    $display("[TB] reset mid-WAIT");
    adr = 32'h10; we = 1'b1; sel = 2'b11; datW = 16'hA5A5; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    watchAcks(2, acks);
    rst = 1'b1;
    watchAcks(1, acks);
    cyc = 1'b0; stb = 1'b0;
    watchAcks(1, acks);
    rst = 1'b0;
    watchAcks(3, acks);
    checkOutput("rstWaitAck", acks, 0);
    checkOutput("rstWaitDat", dat1, 16'h0000);
    applyStimulus(32'h10, 1'b0, 2'b11, 16'h0000, lat, rd);
    checkOutput("rstWaitKeep", rd, 16'hBE34);

    $display("[TB] address window");
    useDut2 = 1'b1;
    adr = 32'h0000_0010; we = 1'b1; sel = 2'b11; datW = 16'h1111; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    watchAcks(20, acks);
    cyc = 1'b0; stb = 1'b0;
    checkOutput("outWindow", acks, 0);
    @(posedge clk); #1;
    applyStimulus(32'h0001_0010, 1'b1, 2'b11, 16'h2468, lat, rd);
    checkOutput("inWindowLat", lat, EXP_LAT);
    applyStimulus(32'h0001_0010, 1'b0, 2'b11, 16'h0000, lat, rd);
    checkOutput("inWindowRd", rd, 16'h2468);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
